// File: rtl/icache_fill.sv
// icache_fill: direct-mapped, one-word-per-line instruction cache with a
// single-outstanding fill handshake, whole-cache invalidate and a
// saturating miss counter.
module icache_fill #(
  parameter int LINES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] curr_addr,
  input  logic        flush,
  output logic [31:0] instr,
  output logic        imem_ready,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid,
  output logic [31:0] miss_count
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE, FILL} state_e;

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       miss_q, miss_d;
  logic              dropped_q, dropped_d;

  logic              valid_q [LINES];
  logic [TAG_W-1:0]  tag_mem [LINES];
  logic [31:0]       data_mem [LINES];

  logic [IDX_W-1:0]  rd_idx, fill_idx;
  logic [TAG_W-1:0]  rd_tag, fill_tag;
  logic              hit, same_word;
  logic              clear_all, install;

  assign rd_idx    = curr_addr[IDX_W+1:2];
  assign rd_tag    = curr_addr[31:IDX_W+2];
  assign fill_idx  = mem_addr_q[IDX_W+1:2];
  assign fill_tag  = mem_addr_q[31:IDX_W+2];
  assign hit       = valid_q[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign same_word = (curr_addr[31:2] == mem_addr_q[31:2]);

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign miss_count = miss_q;

  // Lookup, fill sequencing and output qualification; instr is zero whenever not ready.
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    miss_d     = miss_q;
    dropped_d  = dropped_q;
    clear_all  = 1'b0;
    install    = 1'b0;
    imem_ready = 1'b0;
    instr      = 32'h0;
    case (state_q)
      IDLE: begin
        if (flush) begin
          // Invalidate takes the cycle: no hit reported, no fill launched.
          clear_all = 1'b1;
        end else if (hit) begin
          imem_ready = 1'b1;
          instr      = data_mem[rd_idx];
        end else begin
          state_d    = FILL;
          mem_req_d  = 1'b1;
          mem_addr_d = {curr_addr[31:2], 2'b00};
          dropped_d  = 1'b0;
          if (miss_q != 32'hFFFF_FFFF) miss_d = miss_q + 32'd1;
        end
      end
      FILL: begin
        if (flush) clear_all = 1'b1;
        if (mem_valid) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          dropped_d = 1'b0;
          // A flush seen at any point of the fill (including now) discards the word.
          if (!flush && !dropped_q) begin
            install = 1'b1;
            if (same_word) begin
              imem_ready = 1'b1;
              instr      = mem_rdata;
            end
          end
        end else if (flush) begin
          dropped_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, fill request/address and saturating miss counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'h0;
      miss_q     <= 32'h0;
      dropped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      miss_q     <= miss_d;
      dropped_q  <= dropped_d;
    end
  end

  // Per-line valid bits: reset/flush clear all, a completed fill sets its line.
  for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
    always_ff @(posedge clk) begin
      if (rst || clear_all) begin
        valid_q[gi] <= 1'b0;
      end else if (install && (fill_idx == IDX_W'(gi))) begin
        valid_q[gi] <= 1'b1;
      end
    end
  end

  // Tag and data storage; contents only matter while the line's valid bit is set.
  always_ff @(posedge clk) begin
    if (install) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_icache_fill.sv
// tb_icache_fill: directed scenarios followed by randomized traffic, all
// checked every cycle against a line-level reference model of the cache.
module tb_icache_fill;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] curr_addr;
  logic        flush;
  logic [31:0] instr;
  logic        imem_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic [31:0] miss_count;

  int tests  = 0;
  int failed = 0;

  icache_fill #(.LINES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .curr_addr  (curr_addr),
    .flush      (flush),
    .instr      (instr),
    .imem_ready (imem_ready),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_valid  (mem_valid),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  // Reference model: 16 lines, index = word address mod 16, tag = word address / 16.
  bit          m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_data  [16];
  bit          m_fill;
  bit          m_drop;
  logic [31:0] m_addr;
  logic [31:0] m_miss;

  logic [31:0] o_instr, o_addr, o_miss;
  logic        o_ready, o_req;

  function automatic int midx(input logic [31:0] a);
    return int'((a >> 2) % 16);
  endfunction

  function automatic logic [25:0] mtag(input logic [31:0] a);
    return a[31:6];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_lines();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare outputs mid-cycle, then advance the model.
  task automatic cycle(input bit r, input logic [31:0] a, input bit fl,
                       input bit mv, input logic [31:0] rd, input bit do_chk);
    logic        e_ready;
    logic [31:0] e_instr;
    int          i;
    bit          is_hit;
    rst = r; curr_addr = a; flush = fl; mem_valid = mv; mem_rdata = rd;
    @(negedge clk);
    i = midx(a);
    is_hit  = m_valid[i] && (m_tag[i] == mtag(a));
    e_ready = 1'b0;
    e_instr = 32'h0;
    if (!m_fill) begin
      if (!fl && is_hit) begin e_ready = 1'b1; e_instr = m_data[i]; end
    end else if (mv && !fl && !m_drop && ((a >> 2) == (m_addr >> 2))) begin
      e_ready = 1'b1; e_instr = rd;
    end
    o_ready = imem_ready; o_instr = instr; o_req = mem_req;
    o_addr  = mem_addr;   o_miss  = miss_count;
    if (do_chk) begin
      chk("ready", {31'h0, o_ready}, {31'h0, e_ready});
      chk("instr", o_instr, e_instr);
      chk("mem_req", {31'h0, o_req}, {31'h0, m_fill});
      chk("miss_count", o_miss, m_miss);
      if (m_fill) chk("mem_addr", o_addr, m_addr);
    end
    @(posedge clk);
    if (r) begin
      clear_lines();
      m_fill = 0; m_drop = 0; m_addr = 0; m_miss = 0;
    end else if (!m_fill) begin
      if (fl) clear_lines();
      else if (!is_hit) begin
        m_fill = 1; m_drop = 0; m_addr = a & ~32'h3;
        if (m_miss != 32'hFFFF_FFFF) m_miss++;
      end
    end else begin
      if (fl) clear_lines();
      if (mv) begin
        if (!fl && !m_drop) begin
          m_valid[midx(m_addr)] = 1'b1;
          m_tag[midx(m_addr)]   = mtag(m_addr);
          m_data[midx(m_addr)]  = rd;
        end
        m_fill = 0; m_drop = 0;
      end else if (fl) begin
        m_drop = 1;
      end
    end
    #1;
  endtask

  logic [31:0] base, pc, rd;
  bit          fl, mv, rs, was_fill;
  int          lat;

  initial begin
    clear_lines();
    m_fill = 0; m_drop = 0; m_addr = 0; m_miss = 0;

    // Reset: first cycle has no defined state to compare, second is checked.
    cycle(1, 32'h0, 0, 0, 32'h0, 0);
    cycle(1, 32'h0, 0, 0, 32'h0, 1);
    chk("rst_req", {31'h0, o_req}, 32'h0);
    chk("rst_miss", o_miss, 32'h0);

    // Cold miss at 0x0, memory answers two cycles after the miss.
    cycle(0, 32'h0, 0, 0, 32'h0, 1);
    chk("t1_miss_ready", {31'h0, o_ready}, 32'h0);
    cycle(0, 32'h0, 0, 0, 32'h0, 1);
    chk("t1_req", {31'h0, o_req}, 32'h1);
    chk("t1_addr", o_addr, 32'h0);
    cycle(0, 32'h0, 0, 1, 32'h13, 1);
    chk("t1_bypass_ready", {31'h0, o_ready}, 32'h1);
    chk("t1_bypass_instr", o_instr, 32'h13);

    // Same word, different byte offset: hit with no new fill.
    cycle(0, 32'h2, 0, 0, 32'h0, 1);
    chk("t2_hit_ready", {31'h0, o_ready}, 32'h1);
    chk("t2_hit_instr", o_instr, 32'h13);
    chk("t2_no_req", {31'h0, o_req}, 32'h0);
    chk("t2_miss", o_miss, 32'h1);

    // Conflict on index 1 between 0x04 and 0x44.
    base = o_miss;
    cycle(0, 32'h04, 0, 0, 32'h0, 1);
    cycle(0, 32'h04, 0, 1, 32'hAAAA_AAAA, 1);
    cycle(0, 32'h44, 0, 0, 32'h0, 1);
    cycle(0, 32'h44, 0, 1, 32'hBBBB_BBBB, 1);
    cycle(0, 32'h04, 0, 0, 32'h0, 1);
    chk("t3_conflict_miss", {31'h0, o_ready}, 32'h0);
    cycle(0, 32'h04, 0, 1, 32'hAAAA_AAAA, 1);
    chk("t3_refill_instr", o_instr, 32'hAAAA_AAAA);
    cycle(0, 32'h04, 0, 0, 32'h0, 1);
    chk("t3_miss_count", o_miss, base + 32'd3);

    // Flush during a fill: the returning word is dropped.
    cycle(0, 32'h100, 0, 0, 32'h0, 1);
    cycle(0, 32'h100, 1, 0, 32'h0, 1);
    cycle(0, 32'h100, 0, 1, 32'hCCCC_CCCC, 1);
    chk("t4_drop_ready", {31'h0, o_ready}, 32'h0);
    chk("t4_drop_instr", o_instr, 32'h0);
    cycle(0, 32'h100, 0, 0, 32'h0, 1);
    chk("t4_remiss", {31'h0, o_ready}, 32'h0);
    cycle(0, 32'h100, 0, 1, 32'hCCCC_CCCC, 1);
    chk("t4_refill", o_instr, 32'hCCCC_CCCC);

    // Reset mid-fill, then a stray memory response.
    cycle(0, 32'h200, 0, 0, 32'h0, 1);
    cycle(0, 32'h200, 0, 0, 32'h0, 1);
    cycle(1, 32'h200, 0, 0, 32'h0, 1);
    cycle(0, 32'h0, 0, 1, 32'hDEAD_BEEF, 1);
    chk("t5_req_after_rst", {31'h0, o_req}, 32'h0);
    chk("t5_cached_lost", {31'h0, o_ready}, 32'h0);
    cycle(0, 32'h0, 0, 0, 32'h0, 1);
    chk("t5_refetch_req", {31'h0, o_req}, 32'h1);
    cycle(0, 32'h0, 0, 1, 32'h13, 1);

    // Memory answers on the first FILL cycle.
    cycle(0, 32'h300, 0, 0, 32'h0, 1);
    cycle(0, 32'h300, 0, 1, 32'h1234_5678, 1);
    chk("t6_k0_ready", {31'h0, o_ready}, 32'h1);
    chk("t6_k0_instr", o_instr, 32'h1234_5678);
    chk("t6_k0_req", {31'h0, o_req}, 32'h1);
    cycle(0, 32'h300, 0, 0, 32'h0, 1);
    chk("t6_req_single", {31'h0, o_req}, 32'h0);
    chk("t6_hit", o_instr, 32'h1234_5678);

    // Randomized traffic over a small address pool so hits and conflicts are common.
    lat = 0;
    pc  = 32'h0;
    for (int n = 0; n < 3000; n++) begin
      if (!m_fill || ($urandom_range(0, 7) == 0))
        pc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      fl = ($urandom_range(0, 15) == 0);
      rs = ($urandom_range(0, 199) == 0);
      rd = $urandom;
      if (m_fill) begin
        if (lat == 0) mv = 1;
        else begin mv = 0; lat--; end
      end else begin
        mv = ($urandom_range(0, 9) == 0);
      end
      was_fill = m_fill;
      cycle(rs, pc, fl, mv, rd, 1);
      if (!was_fill && m_fill) lat = $urandom_range(0, 3);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
